bullet_pool_ctrl: RTL and testbench
===================================

// Module: bullet_pool_ctrl
// PURPOSE
//  Parametrised bullet pool: owns N_BULLETS bullet slots, allocates a free slot on a fire request,
//  moves every active bullet vertically once per frame and retires it at the screen edge or on hit.
//  Adds auto-repeat, cooldown, per-slot direction, round-robin allocation and a drop indication.
//  Sits between the player input/ship logic and the pixel mixer / collision detector.
// PARAMETERS
//  N_BULLETS   4    number of slots (1..16)
//  SPEED       4    pixels moved per frame
//  COOLDOWN    6    frames after a successful fire during which requests are ignored (0 = none)
//  REPEAT      15   frames between auto-fires while trigger held (0 = edge-only)
//  ALLOC_RR    0    0 = lowest free index wins; 1 = round-robin starting after last allocated
//  BUL_W, BUL_H 2, 6  bullet sprite size in pixels
//  X_OFS       7    horizontal offset added to ship_x at launch
//  Y_MAX       479  last visible row
// PORTS
//  clk_60hz    in   1   frame clock; all state advances on rising edge
//  reset_n     in   1   asynchronous, active-low reset
//  px, py      in   10  current raster pixel
//  ship_x      in   10  ship left edge
//  ship_y      in   10  ship top edge; down shots launch at ship_y + SHIP_H
//  shoot_up    in   1   fire-upward request (level)
//  shoot_down  in   1   fire-downward request (level)
//  hit         in   N   per-slot kill from collision logic (level, sampled on edge)
//  in_use      out  N   slot active
//  pixel       out  N   slot covers (px,py); combinational, gated by in_use
//  fired       out  1   one-frame pulse: a slot was allocated this edge
//  dropped     out  1   one-frame pulse: valid request found all slots busy
//  active_cnt  out  CW  popcount of in_use, CW = $clog2(N_BULLETS+1)
// BEHAVIOUR
//  Reset: in_use=0, fired=0, dropped=0, active_cnt=0, cooldown/repeat counters=0, rr pointer=N-1,
//   trigger history=1 (trigger held through reset must be released before first shot). Reset mid-flight kills all.
//  Request: trig = shoot_up|shoot_down. Valid request when cooldown==0 and either rising edge of trig
//   or (trig held, REPEAT!=0, repeat counter expired). Direction = up if shoot_up, else down (up wins on both).
//  Trigger FSM: IDLE -(edge)-> HELD; HELD -(~trig)-> IDLE. Repeat counter loads REPEAT on every fire,
//   decrements in HELD, fires at 0 and reloads. An edge-fire blocked only by cooldown is lost, not queued.
//  Allocation uses in_use as registered before the edge. Mode 0: lowest free index. Mode 1: first free index
//   after rr pointer (wrapping N-1 -> 0); pointer updates to allocated index. All busy: dropped=1,
//   no state change; cooldown not loaded.
//  On fire (edge k): slot x = ship_x + X_OFS (10-bit wrap), y = ship_y (up) or ship_y+SHIP_H (down),
//   dir latched, in_use=1 after edge k, fired=1 for that frame, cooldown = COOLDOWN.
//   Newly launched slot does not move on edge k.
//  Motion (each edge, active slot): up: if y < SPEED retire, else y -= SPEED; down: if y + SPEED > Y_MAX
//   retire, else y += SPEED. Arithmetic in 11 bits, no wrap.
//  hit[i]=1 on edge: in_use[i] cleared on that edge (priority over motion). Slot freed by hit/retire is not
//   reallocatable on the same edge. hit on inactive slot: ignored.
//  pixel[i] = in_use[i] && x<=px<x+BUL_W && y<=py<y+BUL_H (11-bit compare).
//  active_cnt registered, consistent with in_use each frame.
// STRUCTURE
//  Package bullet_pkg: SCREEN_W/Y_MAX, SHIP_H, coordinate width (10), dir enum {DIR_UP, DIR_DOWN}.
//  Sub-module bullet_slot (one per slot, generate loop): holds x, y, dir, active; inputs launch, hit;
//   outputs in_use, pixel. Top holds trigger FSM, cooldown/repeat counters, allocator, popcount.
// TESTING
//  1 Reset with shoot_up held, release, press 1 frame -> fired at that edge, in_use=0001, dir up, y=ship_y.
//  2 ship_y=20, SPEED=4, fire up -> y 20,16,12,8,4,0 then retire next edge: in_use=0 six edges after launch.
//  3 Hold shoot_down 60 frames, COOLDOWN=6, REPEAT=15 -> fires at frames 0,15,30,45; active_cnt tracks.
//  4 Fill 4 slots then press -> dropped=1, fired=0, in_use=1111; hit=0010 same edge -> slot 1 free next.
//  5 ALLOC_RR=1: fire, hit slot 0, fire -> second shot uses slot 1, not slot 0.
//  6 Assert reset_n low mid-flight for 1 cycle -> in_use=0, pixel=0 immediately; no fire until release.

Source files
------------

// File: rtl/bullet_pkg.sv
// bullet_pkg: screen geometry, coordinate width and the direction/trigger enums shared by the bullet pool
package bullet_pkg;
   localparam int COORD_W      = 10;
   localparam int SCREEN_W     = 640;
   localparam int SCREEN_Y_MAX = 479;
   localparam int SHIP_H       = 16;
   typedef enum logic {DIR_UP, DIR_DOWN} dir_t;
   typedef enum logic {TRG_IDLE, TRG_HELD} trig_state_t;
endpackage

// File: rtl/bullet_slot.sv
// bullet_slot: one bullet's position, direction and liveness, plus its sprite coverage test
module bullet_slot
   import bullet_pkg::*;
#(
   parameter int SPEED = 4,
   parameter int BUL_W = 2,
   parameter int BUL_H = 6,
   parameter int Y_MAX = SCREEN_Y_MAX
) (
   input  logic               clk_60hz,
   input  logic               reset_n,
   input  logic               launch,
   input  logic [COORD_W-1:0] launch_x,
   input  logic [COORD_W:0]   launch_y,
   input  dir_t               launch_dir,
   input  logic               hit,
   input  logic [COORD_W-1:0] px,
   input  logic [COORD_W-1:0] py,
   output logic               in_use,
   output logic               in_use_nxt,
   output logic               pixel
);
   localparam logic [COORD_W:0] SPD  = (COORD_W+1)'(SPEED);
   localparam logic [COORD_W:0] YLIM = (COORD_W+1)'(Y_MAX);
   localparam logic [COORD_W:0] BW   = (COORD_W+1)'(BUL_W);
   localparam logic [COORD_W:0] BH   = (COORD_W+1)'(BUL_H);
   logic [COORD_W-1:0] x;
   logic [COORD_W:0]   y;
   logic [COORD_W:0]   y_step;
   logic               retire;
   dir_t               dir;
   // one frame of motion: leaving the screen retires, a hit kills first, a launch revives a free slot
   always_comb begin
      retire     = (dir == DIR_UP) ? (y < SPD) : (y + SPD > YLIM);
      y_step     = (dir == DIR_UP) ? y - SPD : y + SPD;
      in_use_nxt = launch | (in_use & ~hit & ~retire);
   end
   // slot state register; a freshly launched bullet holds its launch position for this edge
   always_ff @(posedge clk_60hz or negedge reset_n)
      if (!reset_n) begin
         in_use <= 1'b0;
         x      <= '0;
         y      <= '0;
         dir    <= DIR_UP;
      end else begin
         in_use <= in_use_nxt;
         if (launch) begin
            x   <= launch_x;
            y   <= launch_y;
            dir <= launch_dir;
         end else if (in_use_nxt) begin
            y <= y_step;
         end
      end
   assign pixel = in_use && ({1'b0, px} >= {1'b0, x}) && ({1'b0, px} < {1'b0, x} + BW)
                         && ({1'b0, py} >= y) && ({1'b0, py} < y + BH);
endmodule

// File: rtl/bullet_pool_ctrl.sv
// bullet_pool_ctrl: trigger handling, cooldown/auto-repeat, slot allocation and occupancy count for a bullet pool
module bullet_pool_ctrl
   import bullet_pkg::*;
#(
   parameter int N_BULLETS = 4,
   parameter int SPEED     = 4,
   parameter int COOLDOWN  = 6,
   parameter int REPEAT    = 15,
   parameter int ALLOC_RR  = 0,
   parameter int BUL_W     = 2,
   parameter int BUL_H     = 6,
   parameter int X_OFS     = 7,
   parameter int Y_MAX     = SCREEN_Y_MAX,
   localparam int CW       = $clog2(N_BULLETS + 1)
) (
   input  logic                 clk_60hz,
   input  logic                 reset_n,
   input  logic [COORD_W-1:0]   px,
   input  logic [COORD_W-1:0]   py,
   input  logic [COORD_W-1:0]   ship_x,
   input  logic [COORD_W-1:0]   ship_y,
   input  logic                 shoot_up,
   input  logic                 shoot_down,
   input  logic [N_BULLETS-1:0] hit,
   output logic [N_BULLETS-1:0] in_use,
   output logic [N_BULLETS-1:0] pixel,
   output logic                 fired,
   output logic                 dropped,
   output logic [CW-1:0]        active_cnt
);
   localparam int IW  = (N_BULLETS > 1) ? $clog2(N_BULLETS) : 1;
   localparam int CDW = $clog2(COOLDOWN + 2);
   localparam int RW  = $clog2(REPEAT + 2);
   trig_state_t          state, state_nxt;
   logic                 trig, trig_q, trig_edge, rpt_due, req, fire, any_free;
   logic [CDW-1:0]       cd;
   logic [RW-1:0]        rpt;
   logic [IW-1:0]        rr, alloc;
   logic [N_BULLETS-1:0] launch, alive_nxt;
   logic [CW-1:0]        cnt_nxt;
   logic [COORD_W-1:0]   launch_x;
   logic [COORD_W:0]     launch_y;
   dir_t                 launch_dir;
   int                   base, idx;
   // trigger FSM: a fresh press fires, holding re-fires each time the repeat counter runs out
   always_comb begin
      trig      = shoot_up | shoot_down;
      trig_edge = trig & ~trig_q;
      rpt_due   = (REPEAT != 0) && (state == TRG_HELD) && trig && (rpt <= RW'(1));
      req       = (cd == '0) && (trig_edge || rpt_due);
      state_nxt = (state == TRG_HELD) ? (trig ? TRG_HELD : TRG_IDLE) : (trig_edge ? TRG_HELD : TRG_IDLE);
   end
   // allocator over the pre-edge occupancy: first free slot after the base index, wrapping
   always_comb begin
      base     = (ALLOC_RR != 0) ? int'(rr) : N_BULLETS - 1;
      any_free = 1'b0;
      alloc    = '0;
      idx      = 0;
      for (int k = 1; k <= N_BULLETS; k++) begin
         idx = (base + k) % N_BULLETS;
         if (!any_free && !in_use[idx]) begin
            any_free = 1'b1;
            alloc    = IW'(idx);
         end
      end
      fire       = req & any_free;
      launch     = fire ? (N_BULLETS'(1) << alloc) : '0;
      launch_x   = ship_x + COORD_W'(X_OFS);
      launch_y   = shoot_up ? {1'b0, ship_y} : {1'b0, ship_y} + (COORD_W+1)'(SHIP_H);
      launch_dir = shoot_up ? DIR_UP : DIR_DOWN;
   end
   // popcount of post-edge occupancy so active_cnt updates on the same edge as in_use
   always_comb begin
      cnt_nxt = '0;
      for (int i = 0; i < N_BULLETS; i++) cnt_nxt = cnt_nxt + CW'(alive_nxt[i]);
   end
   // trigger history starts high so a trigger held through reset needs a release before firing
   always_ff @(posedge clk_60hz or negedge reset_n)
      if (!reset_n) begin
         state      <= TRG_IDLE;
         trig_q     <= 1'b1;
         cd         <= '0;
         rpt        <= '0;
         rr         <= IW'(N_BULLETS - 1);
         fired      <= 1'b0;
         dropped    <= 1'b0;
         active_cnt <= '0;
      end else begin
         state      <= state_nxt;
         trig_q     <= trig;
         cd         <= fire ? CDW'(COOLDOWN) : ((cd != '0) ? cd - 1'b1 : cd);
         rpt        <= fire ? RW'(REPEAT) : ((state == TRG_HELD && rpt != '0) ? rpt - 1'b1 : rpt);
         rr         <= fire ? alloc : rr;
         fired      <= fire;
         dropped    <= req & ~any_free;
         active_cnt <= cnt_nxt;
      end
   for (genvar i = 0; i < N_BULLETS; i++) begin : g_slot
      bullet_slot #(
         .SPEED(SPEED),
         .BUL_W(BUL_W),
         .BUL_H(BUL_H),
         .Y_MAX(Y_MAX)
      ) u_slot (
         .clk_60hz  (clk_60hz),
         .reset_n   (reset_n),
         .launch    (launch[i]),
         .launch_x  (launch_x),
         .launch_y  (launch_y),
         .launch_dir(launch_dir),
         .hit       (hit[i]),
         .px        (px),
         .py        (py),
         .in_use    (in_use[i]),
         .in_use_nxt(alive_nxt[i]),
         .pixel     (pixel[i])
      );
   end
endmodule

// File: tb/tb_bullet_pool_ctrl.sv
// tb_bullet_pool_ctrl: directed scenarios plus random play against a behavioural pool model, lowest-free and round-robin builds
module tb_bullet_pool_ctrl;
   import bullet_pkg::*;
   localparam int N = 4, SPD = 4, CD = 6, RPT = 15, XO = 7, YM = 479, BW = 2, BH = 6;
   logic       clk_60hz = 1'b0;
   logic       reset_n = 1'b0;
   logic [9:0] px, py, ship_x, ship_y;
   logic       shoot_up, shoot_down;
   logic [3:0] hit [2];
   logic [3:0] in_use [2];
   logic [3:0] pixel [2];
   logic       fired [2];
   logic       dropped [2];
   logic [2:0] active_cnt [2];
   int         n_chk, n_fail;
   bit         m_act [2][N];
   bit         m_up [2][N];
   int         m_x [2][N];
   int         m_y [2][N];
   int         m_cd [2], m_hc [2], m_rr [2];
   bit         m_held [2], m_prev [2];
   always #5 clk_60hz = ~clk_60hz;
   bullet_pool_ctrl #(.ALLOC_RR(0)) u_lin (
      .clk_60hz(clk_60hz), .reset_n(reset_n), .px(px), .py(py), .ship_x(ship_x), .ship_y(ship_y),
      .shoot_up(shoot_up), .shoot_down(shoot_down), .hit(hit[0]), .in_use(in_use[0]), .pixel(pixel[0]),
      .fired(fired[0]), .dropped(dropped[0]), .active_cnt(active_cnt[0]));
   bullet_pool_ctrl #(.ALLOC_RR(1)) u_rr (
      .clk_60hz(clk_60hz), .reset_n(reset_n), .px(px), .py(py), .ship_x(ship_x), .ship_y(ship_y),
      .shoot_up(shoot_up), .shoot_down(shoot_down), .hit(hit[1]), .in_use(in_use[1]), .pixel(pixel[1]),
      .fired(fired[1]), .dropped(dropped[1]), .active_cnt(active_cnt[1]));
   bit m_fired [2], m_drop [2];
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask
   task automatic model_reset();
      for (int m = 0; m < 2; m++) begin
         for (int i = 0; i < N; i++) m_act[m][i] = 0;
         m_cd[m] = 0; m_hc[m] = RPT; m_rr[m] = N - 1;
         m_held[m] = 0; m_prev[m] = 1; m_fired[m] = 0; m_drop[m] = 0;
      end
   endtask
   // hc counts held frames since the last shot; the pool re-fires once REPEAT of them have elapsed
   task automatic model_step(input int m);
      bit trig, t_edge, due, valid, found;
      int base, idx, alloc;
      trig   = shoot_up | shoot_down;
      t_edge = trig && !m_prev[m];
      due    = (RPT != 0) && m_held[m] && trig && (m_hc[m] + 1 >= RPT);
      valid  = (m_cd[m] == 0) && (t_edge || due);
      base   = (m == 1) ? m_rr[m] : N - 1;
      found  = 0; alloc = 0;
      for (int k = 1; k <= N; k++) begin
         idx = (base + k) % N;
         if (!found && !m_act[m][idx]) begin found = 1; alloc = idx; end
      end
      for (int i = 0; i < N; i++)
         if (m_act[m][i]) begin
            if (hit[m][i]) m_act[m][i] = 0;
            else if (m_up[m][i]) begin
               if (m_y[m][i] < SPD) m_act[m][i] = 0; else m_y[m][i] -= SPD;
            end else begin
               if (m_y[m][i] + SPD > YM) m_act[m][i] = 0; else m_y[m][i] += SPD;
            end
         end
      if (valid && found) begin
         m_act[m][alloc] = 1;
         m_x[m][alloc]   = (int'(ship_x) + XO) % 1024;
         m_y[m][alloc]   = shoot_up ? int'(ship_y) : int'(ship_y) + SHIP_H;
         m_up[m][alloc]  = shoot_up;
         m_cd[m] = CD; m_hc[m] = 0; m_rr[m] = alloc;
      end else begin
         m_cd[m] = (m_cd[m] > 0) ? m_cd[m] - 1 : 0;
         if (m_held[m]) m_hc[m] = (m_hc[m] + 1 > RPT) ? RPT : m_hc[m] + 1;
      end
      m_fired[m] = valid && found;
      m_drop[m]  = valid && !found;
      m_held[m]  = m_held[m] ? trig : t_edge;
      m_prev[m]  = trig;
   endtask
   task automatic cmp_all();
      logic [3:0] e_use, e_pix;
      int cnt;
      for (int m = 0; m < 2; m++) begin
         e_use = '0; e_pix = '0; cnt = 0;
         for (int i = 0; i < N; i++) begin
            e_use[i] = m_act[m][i];
            cnt += m_act[m][i];
            e_pix[i] = m_act[m][i] && int'(px) >= m_x[m][i] && int'(px) < m_x[m][i] + BW
                                   && int'(py) >= m_y[m][i] && int'(py) < m_y[m][i] + BH;
         end
         check($sformatf("d%0d_in_use", m), in_use[m], e_use);
         check($sformatf("d%0d_pixel", m), pixel[m], e_pix);
         check($sformatf("d%0d_active_cnt", m), active_cnt[m], cnt);
         check($sformatf("d%0d_fired", m), fired[m], m_fired[m]);
         check($sformatf("d%0d_dropped", m), dropped[m], m_drop[m]);
      end
   endtask
   task automatic step();
      @(posedge clk_60hz);
      model_step(0);
      model_step(1);
      #1;
      cmp_all();
   endtask
   initial begin
      int mm, kk;
      n_chk = 0; n_fail = 0;
      shoot_up = 1; shoot_down = 0; ship_x = 100; ship_y = 20; px = 0; py = 0;
      hit[0] = '0; hit[1] = '0;
      model_reset();
      repeat (2) @(posedge clk_60hz);
      #1;
      cmp_all();
      check("rst_cnt", active_cnt[0], 0);
      check("rst_fired", fired[0], 0);
      reset_n = 1;
      step(); step();
      check("t1_held_no_fire", fired[0], 0);
      shoot_up = 0; step();
      shoot_up = 1; step();
      check("t1_fired", fired[0], 1);
      check("t1_in_use", in_use[0], 4'b0001);
      shoot_up = 0; px = 107; py = 20; #1;
      check("t1_pixel_launch", pixel[0], 4'b0001);
      py = 19; #1;
      check("t1_pixel_above", pixel[0], 4'b0000);
      py = 16;
      for (int j = 1; j <= 6; j++) begin
         step();
         check("t2_alive", in_use[0][0], j < 6);
         if (j == 1) check("t2_moved_up", pixel[0][0], 1);
      end
      step(); step();
      ship_y = 100; shoot_down = 1;
      for (int j = 0; j < 60; j++) begin
         step();
         check("t3_repeat_fire", fired[0], (j % 15) == 0);
      end
      check("t3_active", active_cnt[0], 4);
      shoot_down = 0; step();
      check("t4_full", in_use[0], 4'hf);
      shoot_up = 1; hit[0] = 4'b0010; hit[1] = 4'b0010; step();
      check("t4_dropped", dropped[0], 1);
      check("t4_no_fire", fired[0], 0);
      check("t4_hit_freed", in_use[0], 4'b1101);
      shoot_up = 0; hit[0] = '0; hit[1] = '0; step();
      shoot_up = 1; step();
      check("t4_refill", fired[0], 1);
      check("t4_refill_use", in_use[0], 4'hf);
      px = 107; py = 100; #1;
      check("t6_pixel_live", pixel[0], 4'b0010);
      reset_n = 0; #1;
      model_reset();
      check("t6_rst_in_use", in_use[0], 0);
      check("t6_rst_pixel", pixel[0], 0);
      @(posedge clk_60hz); #1;
      cmp_all();
      reset_n = 1;
      step(); step();
      check("t6_no_fire", fired[0], 0);
      ship_y = 300; shoot_up = 0; step();
      shoot_up = 1; step();
      check("t5_first", in_use[1], 4'b0001);
      shoot_up = 0; hit[1] = 4'b0001; step();
      hit[1] = '0;
      check("t5_hit", in_use[1], 4'b0000);
      repeat (6) step();
      shoot_up = 1; step();
      check("t5_rr_next", in_use[1], 4'b0010);
      check("t5_lin_next", in_use[0], 4'b0011);
      shoot_up = 0;
      for (int j = 0; j < 1500; j++) begin
         if ($urandom_range(5) == 0) shoot_up = ~shoot_up;
         if ($urandom_range(5) == 0) shoot_down = ~shoot_down;
         if ($urandom_range(7) == 0) ship_x = 10'($urandom);
         if ($urandom_range(7) == 0) ship_y = 10'($urandom);
         for (int m = 0; m < 2; m++) hit[m] = 4'($urandom) & 4'($urandom) & 4'($urandom);
         mm = int'($urandom_range(1));
         kk = int'($urandom_range(N - 1));
         if ($urandom_range(1) == 1) begin
            px = 10'(m_x[mm][kk] + int'($urandom_range(3)) - 1);
            py = 10'(m_y[mm][kk] + int'($urandom_range(7)) - 1);
         end else begin
            px = 10'($urandom);
            py = 10'($urandom_range(511));
         end
         step();
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
